// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounced three-button front end plus the run/set mode FSM
// for the six-digit BCD HH:MM:SS clock.
//
//  state  | meaning
//  RUN    | time advances on tick_1hz, inc/dec ignored
//  SET_HH | hours editable, time frozen
//  SET_MM | minutes editable, time frozen
//  SET_SS | seconds editable, time frozen
module time_set_ctrl #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic       tick_1hz,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic [1:0] blink_sel,
   output logic       set_active
);

   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {RUN, SET_HH, SET_MM, SET_SS} state_t;

   // bit 0 mode, bit 1 inc, bit 2 dec
   logic [2:0]    sync1, sync2, stable, stable_d;
   logic [CW-1:0] db_cnt [0:2];
   logic          mode_press, inc_press, dec_press;

   state_t     state_q, state_d;
   logic [7:0] hh_d, mm_d, ss_d;
   logic [1:0] blink_d;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
      if (v == max_v)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
      if (v == 8'h00)
         return max_v;
      else if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      else
         return {v[7:4], v[3:0] - 4'd1};
   endfunction

   // Synchronize, debounce and remember the previous debounced level per button.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1    <= 3'b000;
         sync2    <= 3'b000;
         stable   <= 3'b000;
         stable_d <= 3'b000;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync1    <= {btn_dec, btn_inc, btn_mode};
         sync2    <= sync1;
         stable_d <= stable;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_MAX) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign mode_press = stable[0] & ~stable_d[0];
   assign inc_press  = stable[1] & ~stable_d[1];
   assign dec_press  = stable[2] & ~stable_d[2];

   // Next state and next time; mode wins over edits, inc+dec together cancel.
   always_comb begin
      state_d = state_q;
      hh_d    = hh;
      mm_d    = mm;
      ss_d    = ss;
      blink_d = 2'b11;
      unique case (state_q)
         RUN: begin
            if (tick_1hz) begin
               if (ss == 8'h59) begin
                  ss_d = 8'h00;
                  if (mm == 8'h59) begin
                     mm_d = 8'h00;
                     hh_d = bcd_inc(hh, 8'h23);
                  end else begin
                     mm_d = bcd_inc(mm, 8'h59);
                  end
               end else begin
                  ss_d = bcd_inc(ss, 8'h59);
               end
            end
            if (mode_press) state_d = SET_HH;
         end
         SET_HH: begin
            if (mode_press)                  state_d = SET_MM;
            else if (inc_press && !dec_press) hh_d = bcd_inc(hh, 8'h23);
            else if (dec_press && !inc_press) hh_d = bcd_dec(hh, 8'h23);
         end
         SET_MM: begin
            if (mode_press)                  state_d = SET_SS;
            else if (inc_press && !dec_press) mm_d = bcd_inc(mm, 8'h59);
            else if (dec_press && !inc_press) mm_d = bcd_dec(mm, 8'h59);
         end
         SET_SS: begin
            if (mode_press)                  state_d = RUN;
            else if (inc_press && !dec_press) ss_d = bcd_inc(ss, 8'h59);
            else if (dec_press && !inc_press) ss_d = bcd_dec(ss, 8'h59);
         end
         default: state_d = RUN;
      endcase
      unique case (state_d)
         SET_HH:  blink_d = 2'b00;
         SET_MM:  blink_d = 2'b01;
         SET_SS:  blink_d = 2'b10;
         default: blink_d = 2'b11;
      endcase
   end

   // State and all outputs are registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RUN;
         hh         <= 8'h00;
         mm         <= 8'h00;
         ss         <= 8'h00;
         blink_sel  <= 2'b11;
         set_active <= 1'b0;
      end else begin
         state_q    <= state_d;
         hh         <= hh_d;
         mm         <= mm_d;
         ss         <= ss_d;
         blink_sel  <= blink_d;
         set_active <= (state_d != RUN);
      end
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a short debounce window.
module tb_time_set_ctrl;

   localparam int DB = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       btn_dec = 1'b0;
   logic       tick_1hz = 1'b0;
   logic [7:0] hh, mm, ss;
   logic [1:0] blink_sel;
   logic       set_active;

   int errors = 0;
   int checks = 0;

   time_set_ctrl #(.DB_CYCLES(DB)) dut (
      .clk(clk), .rst_n(rst_n),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .tick_1hz(tick_1hz),
      .hh(hh), .mm(mm), .ss(ss),
      .blink_sel(blink_sel), .set_active(set_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_time(input string tag, input logic [23:0] exp);
      check(tag, {hh, mm, ss}, exp);
   endtask

   task automatic check_mode(input string tag, input logic [1:0] bsel, input logic sact);
      check(tag, {21'd0, blink_sel, set_active}, {21'd0, bsel, sact});
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) tick_1hz = 1'b1;
         @(negedge clk) tick_1hz = 1'b0;
      end
   endtask

   // which: bit0 mode, bit1 inc, bit2 dec; all selected buttons move together
   task automatic press(input logic [2:0] which);
      @(negedge clk);
      btn_mode = which[0];
      btn_inc  = which[1];
      btn_dec  = which[2];
      cycles(DB + 8);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      btn_dec  = 1'b0;
      cycles(DB + 8);
   endtask

   initial begin
      // reset and idle counting
      rst_n = 1'b0;
      cycles(3);
      rst_n = 1'b1;
      cycles(1);
      check_time("reset_time", 24'h000000);
      check_mode("reset_mode", 2'b11, 1'b0);
      tick(61);
      check_time("run_61_ticks", 24'h000101);

      // SET_HH: frozen time, dec wrap, inc wrap
      press(3'b001);
      check_mode("enter_set_hh", 2'b00, 1'b1);
      tick(3);
      check_time("frozen_in_hh", 24'h000101);
      press(3'b100);
      check_time("hh_dec_wrap", 24'h230101);
      press(3'b010);
      check_time("hh_inc_wrap", 24'h000101);
      press(3'b100);
      check_time("hh_preset_23", 24'h230101);

      // SET_MM: frozen, borrow/wrap down to 59
      press(3'b001);
      check_mode("enter_set_mm", 2'b01, 1'b1);
      tick(2);
      check_time("frozen_in_mm", 24'h230101);
      press(3'b100);
      press(3'b100);
      check_time("mm_dec_wrap", 24'h235901);

      // SET_SS: 01 -> 10, borrow to 09, down to 59, inc wrap to 00
      press(3'b001);
      check_mode("enter_set_ss", 2'b10, 1'b1);
      for (int i = 0; i < 9; i++) press(3'b010);
      check_time("ss_inc_to_10", 24'h235910);
      press(3'b100);
      check_time("ss_borrow_09", 24'h235909);
      for (int i = 0; i < 10; i++) press(3'b100);
      check_time("ss_dec_to_59", 24'h235959);
      press(3'b010);
      check_time("ss_inc_wrap", 24'h235900);
      press(3'b100);
      check_time("ss_dec_wrap", 24'h235959);

      // back to RUN and full rollover
      press(3'b001);
      check_mode("back_to_run", 2'b11, 1'b0);
      check_time("run_preset", 24'h235959);
      @(negedge clk) tick_1hz = 1'b1;
      @(negedge clk) tick_1hz = 1'b0;
      check_time("rollover", 24'h000000);

      // inc ignored in RUN
      press(3'b010);
      check_time("inc_ignored_run", 24'h000000);

      // mode+inc together in SET_HH: transition taken, edit dropped
      press(3'b001);
      check_mode("enter_hh_again", 2'b00, 1'b1);
      press(3'b011);
      check_mode("mode_inc_to_mm", 2'b01, 1'b1);
      check_time("mode_inc_hh_kept", 24'h000000);

      // bouncy inc then a clean hold: exactly one increment
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         btn_inc = ~btn_inc;
         cycles(3);
      end
      check_time("bounce_no_press", 24'h000000);
      btn_inc = 1'b1;
      cycles(20);
      btn_inc = 1'b0;
      cycles(DB + 8);
      check_time("debounce_one_inc", 24'h000100);

      // inc+dec together: field unchanged
      press(3'b110);
      check_time("inc_dec_cancel", 24'h000100);
      check_mode("still_set_mm", 2'b01, 1'b1);

      // reset mid-edit and mid-debounce
      @(negedge clk) btn_inc = 1'b1;
      cycles(5);
      rst_n = 1'b0;
      cycles(1);
      rst_n = 1'b1;
      cycles(DB + 8);
      btn_inc = 1'b0;
      cycles(DB + 8);
      check_time("reset_mid_edit", 24'h000000);
      check_mode("reset_mid_mode", 2'b11, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL timeout: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
